// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - memory request bus between sequencer and memory
interface mem_access_sequencer_if #(
  parameter int unsigned DATA_BYTES = 4
);
  logic                  read_o;
  logic                  write_o;
  logic [DATA_BYTES-1:0] byteenable_o;
  logic                  addr_sel_o;
  logic                  waitrequest_i;

  modport master (
    output read_o,
    output write_o,
    output byteenable_o,
    output addr_sel_o,
    input  waitrequest_i
  );

  modport slave (
    input  read_o,
    input  write_o,
    input  byteenable_o,
    input  addr_sel_o,
    output waitrequest_i
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - fetch/load/store sequencer with byte lanes, alignment checks and wait timeout
module mem_access_sequencer #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned OFFSET_W   = $clog2(DATA_BYTES),
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_access_sequencer_if.master bus,
  input  logic                   is_load_i,
  input  logic                   is_store_i,
  input  logic [2:0]             access_type_i,
  input  logic [OFFSET_W-1:0]    byte_offset_i,
  input  logic                   reg_write_req_i,
  input  logic                   halt_req_i,
  output logic                   ir_write_en_o,
  output logic                   mdr_write_en_o,
  output logic                   pc_write_en_o,
  output logic                   regfile_write_en_o,
  output logic [2:0]             state_o,
  output logic                   active_o,
  output logic                   fault_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [2:0] AT_WORD  = 3'd0;
  localparam logic [2:0] AT_HALF  = 3'd1;
  localparam logic [2:0] AT_BYTE  = 3'd2;
  localparam logic [2:0] AT_LEFT  = 3'd3;
  localparam logic [2:0] AT_RIGHT = 3'd4;

  localparam logic [DATA_BYTES-1:0] ALL_ONES = '1;

  // Counter only needs to reach WAIT_LIMIT; it saturates at its own maximum.
  localparam int unsigned      CNT_W   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_d;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_inc;
  logic                  timeout;
  logic                  ir_pend, mdr_pend;
  logic [DATA_BYTES-1:0] be_calc;
  logic                  access_ok;
  logic                  req_rd, req_wr, req_sel, held, complete;
  logic [DATA_BYTES-1:0] req_be;

  assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign timeout      = (WAIT_LIMIT > 0) && (32'(wait_cnt_inc) >= WAIT_LIMIT);

  // Byte-lane pattern and alignment legality for the data access.
  // DATA_BYTES is a power of two, so DATA_BYTES-1-o equals the bitwise inverse of o.
  always_comb begin
    be_calc   = '0;
    access_ok = 1'b1;
    case (access_type_i)
      AT_WORD: begin
        be_calc   = ALL_ONES;
        access_ok = (byte_offset_i == '0);
      end
      AT_HALF: begin
        be_calc   = DATA_BYTES'(2'b11) << byte_offset_i;
        access_ok = !byte_offset_i[0];
      end
      AT_BYTE:  be_calc = DATA_BYTES'(1) << byte_offset_i;
      AT_LEFT:  be_calc = ALL_ONES << byte_offset_i;
      AT_RIGHT: be_calc = ALL_ONES >> (~byte_offset_i);
      default:  access_ok = 1'b0;
    endcase
  end

  // Next state, bus request and completion decode for the current state.
  always_comb begin
    state_d  = state;
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    req_sel  = 1'b0;
    req_be   = '0;
    held     = 1'b0;
    complete = 1'b0;
    case (state)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        req_rd = 1'b1;
        req_be = ALL_ONES;
        if (bus.waitrequest_i) held = 1'b1;
        else                   state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (is_load_i) begin
          if (!access_ok) begin
            state_d = S_FAULT;
          end else begin
            req_rd  = 1'b1;
            req_sel = 1'b1;
            req_be  = be_calc;
            if (bus.waitrequest_i) held = 1'b1;
            else                   state_d = S_EXEC2;
          end
        end else begin
          state_d = S_EXEC2;
        end
      end
      S_EXEC2: begin
        if (is_store_i && !is_load_i) begin
          if (!access_ok) begin
            state_d = S_FAULT;
          end else begin
            req_wr  = 1'b1;
            req_sel = 1'b1;
            req_be  = be_calc;
            if (bus.waitrequest_i) held = 1'b1;
            else                   complete = 1'b1;
          end
        end else begin
          complete = 1'b1;
        end
        if (complete) state_d = halt_req_i ? S_HALT : S_FETCH;
      end
      default: state_d = state;
    endcase
    // A request stalled for WAIT_LIMIT cycles is abandoned from the next cycle on.
    if (held && timeout) state_d = S_FAULT;
  end

  // State, wait counter and the read-data strobes that trail acceptance by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ir_pend  <= 1'b0;
      mdr_pend <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= (held && (state_d == state)) ? wait_cnt_inc : '0;
      ir_pend  <= (state == S_FETCH) && (state_d == S_EXEC1);
      mdr_pend <= (state == S_EXEC1) && req_rd && !held;
    end
  end

  assign bus.read_o         = req_rd;
  assign bus.write_o        = req_wr;
  assign bus.addr_sel_o     = req_sel;
  assign bus.byteenable_o   = req_be;
  assign ir_write_en_o      = ir_pend;
  assign mdr_write_en_o     = mdr_pend;
  assign pc_write_en_o      = complete;
  assign regfile_write_en_o = complete && reg_write_req_i;
  assign state_o            = state;
  assign active_o           = (state != S_HALT) && (state != S_FAULT);
  assign fault_o            = (state == S_FAULT);

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter DATA_BYTES, default 4: bus width in bytes; power of two, at least 2.
REQ-002 Parameter OFFSET_W, default $clog2(DATA_BYTES): byte-offset width; derived, never overridden.
REQ-003 Parameter WAIT_LIMIT, default 15: consecutive waitrequest cycles allowed before fault; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 waitrequest_i  input  1  memory not accepting the current read_o/write_o.
REQ-007 is_load_i  input  1  decoded instruction is a load; valid from the first EXEC1 cycle.
REQ-008 is_store_i  input  1  decoded instruction is a store; valid from the first EXEC1 cycle.
REQ-009 access_type_i  input  3  access type: 0 WORD, 1 HALF, 2 BYTE, 3 LEFT, 4 RIGHT; 5-7 illegal.
REQ-010 byte_offset_i  input  OFFSET_W  low address bits of the effective address.
REQ-011 reg_write_req_i  input  1  instruction writes the register file.
REQ-012 halt_req_i  input  1  next PC is the halt address.
REQ-013 read_o, write_o  output  1 each  memory read/write request.
REQ-014 byteenable_o  output  DATA_BYTES  byte lanes of the current access.
REQ-015 addr_sel_o  output  1  0 = PC address, 1 = data address.
REQ-016 ir_write_en_o, mdr_write_en_o, pc_write_en_o, regfile_write_en_o  output  1 each  datapath register write strobes.
REQ-017 state_o  output  3  IDLE=0, FETCH=1, EXEC1=2, EXEC2=3, HALT=4, FAULT=5.
REQ-018 active_o  output  1  high in every state except HALT and FAULT.
REQ-019 fault_o  output  1  high in FAULT.

Function
REQ-020 IDLE: all bus outputs and strobes low; go to FETCH unconditionally on the next edge.
REQ-021 FETCH: read_o=1, addr_sel_o=0, byteenable_o all ones; hold while waitrequest_i=1; on acceptance (waitrequest_i=0), go to EXEC1.
REQ-022 Read data is valid exactly one cycle after acceptance: ir_write_en_o=1 on the first EXEC1 cycle only; mdr_write_en_o=1 on the first EXEC2 cycle after an accepted load only.
REQ-023 EXEC1 with is_load_i=1: read_o=1, addr_sel_o=1, byteenable_o per REQ-026; hold while waitrequest_i=1; on acceptance, go to EXEC2.
REQ-024 EXEC1 with is_load_i=0: one cycle, no bus request; then EXEC2.
REQ-025 EXEC2 with is_store_i=1 and is_load_i=0: write_o=1, addr_sel_o=1, byteenable_o per REQ-026; hold while waitrequest_i=1.
REQ-026 Byte enables, truncated to DATA_BYTES bits, with o = byte_offset_i:
- WORD: all ones.
- HALF: 0b11<<o.
- BYTE: 1<<o.
- LEFT: all ones<<o.
- RIGHT: all ones>>(DATA_BYTES-1-o).
REQ-027 Misaligned access, checked in the cycle the request would be issued, and illegal access_type_i: go to FAULT with read_o/write_o low in that cycle.
- WORD: fault if o != 0.
- HALF: fault if o is odd.
REQ-028 EXEC2 completion cycle (first cycle, or the store acceptance cycle):
- pc_write_en_o=1.
- regfile_write_en_o=reg_write_req_i.
- Next state HALT if halt_req_i=1, else FETCH.
REQ-029 is_load_i and is_store_i both high: treated as a load only; no write issued.
REQ-030 access_type_i and byte_offset_i are ignored when the instruction is neither a load nor a store.
REQ-031 Wait counter: counts consecutive cycles with a request held by waitrequest_i; clears on acceptance. When it reaches WAIT_LIMIT (WAIT_LIMIT>0), go to FAULT next edge, dropping the request. The counter saturates and never wraps.
REQ-032 HALT and FAULT are terminal until reset: all bus outputs and strobes low.
REQ-033 byteenable_o = 0 whenever read_o and write_o are both low.

Reset
REQ-034 While reset=1, asynchronously:
- state = IDLE, wait counter = 0, all outputs low.
- active_o = 1.
- Any in-flight request is abandoned.

Verification
REQ-035 Non-memory instruction with reg_write_req_i=1 and no waitrequest -> state sequence 1,2,3,1; ir_write_en_o in cycle 2; pc_write_en_o and regfile_write_en_o in cycle 3.
REQ-036 Load, BYTE, o=2, DATA_BYTES=4, waitrequest high for 3 EXEC1 cycles -> read_o held 4 cycles with byteenable_o=0100; mdr_write_en_o on the first EXEC2 cycle.
REQ-037 Store, HALF, o=1 -> FAULT next edge, write_o never asserted, fault_o=1, active_o=0.
REQ-038 WAIT_LIMIT=15, waitrequest stuck high in FETCH -> read_o high 15 cycles, then FAULT; WAIT_LIMIT=0 -> FETCH held indefinitely.
REQ-039 halt_req_i=1 at EXEC2 -> pc_write_en_o for one cycle, then HALT; no further requests.
REQ-040 reset asserted mid-store while waitrequest is high -> write_o drops without a clock edge; IDLE, then FETCH after release.
REQ-041 DATA_BYTES=8, LEFT, o=5 -> byteenable_o=11100000; RIGHT, o=5 -> 00111111.
